// File: rtl/button_renderer.sv
// Bevelled button tile overlay on the VGA pixel stream.
// Handshakes with the board sequencer through done_x / done_y pulses.
module button_renderer #(
  parameter int          BORDER     = 2,
  parameter logic [11:0] COL_LIGHT  = 12'hFFF,
  parameter logic [11:0] COL_SHADOW = 12'h555,
  parameter logic [11:0] COL_FACE   = 12'hBBB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw_button,
  input  logic [6:0]  button_size,
  input  logic [10:0] button_xpos,
  input  logic [10:0] button_ypos,
  input  logic [4:0]  button_num,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        done_x,
  output logic        done_y
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic [6:0]  size_q, size_d;
  logic [4:0]  num_q, num_d;
  logic [4:0]  col_q, col_d;
  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q, rgb_d;
  logic        done_x_q, done_x_d;
  logic        done_y_q, done_y_d;

  logic [11:0] x_end, y_end, dx, dy;
  logic [4:0]  last_col;
  logic        fs, blank, active, in_tile, end_px, vblnk_rise;

  always_comb begin
    fs         = (hcount_in == 11'd0) && (vcount_in == 11'd0);
    blank      = hblnk_in || vblnk_in;
    x_end      = {1'b0, xpos_q} + {5'd0, size_q} - 12'd1;
    y_end      = {1'b0, ypos_q} + {5'd0, size_q} - 12'd1;
    dx         = {1'b0, hcount_in} - {1'b0, xpos_q};
    dy         = {1'b0, vcount_in} - {1'b0, ypos_q};
    // size 0 would wrap the extent to the full range, so gate it off
    active     = (state_q == DRAW) && !blank && (size_q != 7'd0);
    in_tile    = active
              && (hcount_in >= xpos_q) && ({1'b0, hcount_in} <= x_end)
              && (vcount_in >= ypos_q) && ({1'b0, vcount_in} <= y_end);
    end_px     = active
              && ({1'b0, hcount_in} == x_end)
              && ({1'b0, vcount_in} == y_end);
    vblnk_rise = vblnk_in && !vblnk_q;
    last_col   = (num_q == 5'd0) ? 5'd0 : num_q - 5'd1;

    rgb_d = rgb_in;
    if (in_tile) begin
      if (dx < 12'(BORDER) || dy < 12'(BORDER))
        rgb_d = COL_LIGHT;
      else if (dx + 12'(BORDER) >= {5'd0, size_q}
            || dy + 12'(BORDER) >= {5'd0, size_q})
        rgb_d = COL_SHADOW;
      else
        rgb_d = COL_FACE;
    end
  end

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    size_d   = size_q;
    num_d    = num_q;
    col_d    = col_q;
    done_x_d = 1'b0;
    done_y_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (fs && draw_button) begin
          xpos_d  = button_xpos;
          ypos_d  = button_ypos;
          size_d  = button_size;
          num_d   = button_num;
          state_d = DRAW;
        end else if (state_q == IDLE || fs) begin
          state_d = IDLE;
          col_d   = 5'd0;
        end
      end
      DRAW: begin
        if (end_px || vblnk_rise) begin
          done_x_d = 1'b1;
          state_d  = DONE;
          if (col_q == last_col) begin
            done_y_d = 1'b1;
            col_d    = 5'd0;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xpos_q   <= '0;
      ypos_q   <= '0;
      size_q   <= '0;
      num_q    <= '0;
      col_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
      done_x_q <= 1'b0;
      done_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      size_q   <= size_d;
      num_q    <= num_d;
      col_q    <= col_d;
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      hblnk_q  <= hblnk_in;
      vblnk_q  <= vblnk_in;
      rgb_q    <= rgb_d;
      done_x_q <= done_x_d;
      done_y_q <= done_y_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;
  assign done_x     = done_x_q;
  assign done_y     = done_y_q;

endmodule
